// File: rtl/controle_medida_periodica.sv
// controle_medida_periodica: periodic/manual ultrasonic measurement sequencer with pronto timeout.
// Define RETENTATIVA_EN to retry once (via RETENTA) before declaring a timeout failure.
module controle_medida_periodica #(
    parameter int INTERVALO     = 50_000_000,
    parameter int TIMEOUT       = 1_500_000,
    parameter int LARGURA_MEDIR = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        medir_manual,
    input  logic        pronto,
    input  logic [11:0] medida,
    output logic        medir,
    output logic [11:0] dado,
    output logic        dado_valido,
    output logic        erro,
    output logic        ocupado,
    output logic [3:0]  db_estado
);
    localparam int MAIOR_AT = INTERVALO > TIMEOUT ? INTERVALO : TIMEOUT;
    localparam int MAIOR    = MAIOR_AT > LARGURA_MEDIR ? MAIOR_AT : LARGURA_MEDIR;
    localparam int W        = $clog2(MAIOR) + 1;

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        PULSO    = 4'd1,
        AGUARDA  = 4'd2,
        REGISTRA = 4'd3,
        FALHA    = 4'd4,
        ESPERA   = 4'd5
`ifdef RETENTATIVA_EN
        , RETENTA = 4'd6
`endif
    } estado_t;

    estado_t        estado, nxt, destino_timeout;
    logic [W-1:0]   cnt;
    logic           pronto_d, pronto_ed;

    assign pronto_ed = pronto & ~pronto_d;

`ifdef RETENTATIVA_EN
    logic tentativa;
    assign destino_timeout = tentativa ? FALHA : RETENTA;
    always_ff @(posedge clock)
        if (reset)
            tentativa <= 1'b0;
        else
            tentativa <= (estado == REGISTRA || estado == FALHA) ? 1'b0 : (nxt == RETENTA) ? 1'b1 : tentativa;
`else
    assign destino_timeout = FALHA;
`endif

    // one shared counter: cleared on every state entry, so it never wraps
    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= INICIAL;
            cnt         <= '0;
            pronto_d    <= 1'b0;
            medir       <= 1'b0;
            dado        <= '0;
            dado_valido <= 1'b0;
            erro        <= 1'b0;
        end else begin
            estado      <= nxt;
            cnt         <= (nxt != estado || estado == INICIAL) ? '0 : cnt + W'(1);
            pronto_d    <= pronto;
            medir       <= nxt == PULSO;
            dado_valido <= estado == REGISTRA;
            dado        <= (estado == REGISTRA) ? medida : dado;
            erro        <= (estado == REGISTRA) ? 1'b0 : (estado == FALHA) ? 1'b1 : erro;
        end
    end

    always_comb begin
        nxt = estado;
        case (estado)
            INICIAL:         nxt = (ligar || medir_manual) ? PULSO : INICIAL;
            PULSO:           nxt = (cnt == W'(LARGURA_MEDIR - 1)) ? AGUARDA : PULSO;
            AGUARDA:         nxt = pronto_ed ? REGISTRA : (cnt == W'(TIMEOUT - 1)) ? destino_timeout : AGUARDA;
            REGISTRA, FALHA: nxt = ligar ? ESPERA : INICIAL;
            ESPERA:          nxt = medir_manual ? PULSO : !ligar ? INICIAL : (cnt == W'(INTERVALO - 1)) ? PULSO : ESPERA;
`ifdef RETENTATIVA_EN
            RETENTA:         nxt = PULSO;
`endif
            default:         nxt = INICIAL;
        endcase
    end

    always_comb begin
        ocupado   = estado inside {PULSO, AGUARDA, REGISTRA, FALHA}
`ifdef RETENTATIVA_EN
                    || estado == RETENTA
`endif
                    ;
        db_estado = estado;
    end
endmodule

// File: tb/tb_controle_medida_periodica.sv
// tb_controle_medida_periodica: directed scenarios with randomized sensor delays and BCD readings.
module tb_controle_medida_periodica;
    localparam int INTERVALO = 2000;
    localparam int TIMEOUT   = 1000;
    localparam int LARGURA   = 5;

    logic        clock = 1'b0;
    logic        reset, ligar, medir_manual, pronto;
    logic [11:0] medida;
    logic        medir, dado_valido, erro, ocupado;
    logic [11:0] dado;
    logic [3:0]  db_estado;

    int          tests = 0;
    int          fails = 0;
    logic [11:0] ultimo;

    controle_medida_periodica #(
        .INTERVALO(INTERVALO),
        .TIMEOUT(TIMEOUT),
        .LARGURA_MEDIR(LARGURA)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ligar(ligar),
        .medir_manual(medir_manual),
        .pronto(pronto),
        .medida(medida),
        .medir(medir),
        .dado(dado),
        .dado_valido(dado_valido),
        .erro(erro),
        .ocupado(ocupado),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #900_000;
        $display("FAIL watchdog: observed no end of run, expected $finish before limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_medir(output int n);
        n = 0;
        while (medir !== 1'b1 && n < 10000) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [11:0] bcd_rand();
        return {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
    endfunction

    // Called with medir just observed high; sensor answers after `atraso` cycles in AGUARDA.
    task automatic medicao(input int atraso, input logic [11:0] val, input bit drop_ligar,
                           input bit manual, input logic [3:0] exp_fim);
        int w;
        int extra;
        chk("pulso_estado", 32'(db_estado), 32'd1);
        chk("pulso_ocupado", 32'(ocupado), 32'd1);
        w = 0;
        while (medir === 1'b1 && w < 100) begin
            w++;
            tick();
        end
        chk("largura_medir", w, LARGURA);
        chk("aguarda_estado", 32'(db_estado), 32'd2);
        extra = 0;
        for (int i = 0; i < atraso; i++) begin
            if (manual && i == atraso / 2) medir_manual = 1'b1;
            if (drop_ligar && i == atraso / 2) ligar = 1'b0;
            tick();
            medir_manual = 1'b0;
            if (medir === 1'b1) extra++;
        end
        chk("medir_extra", extra, 0);
        pronto = 1'b1;
        medida = val;
        tick();
        chk("registra_estado", 32'(db_estado), 32'd3);
        tick();
        chk("dado_valido", 32'(dado_valido), 32'd1);
        chk("dado", 32'(dado), 32'(val));
        chk("erro_limpo", 32'(erro), 32'd0);
        ultimo = val;
        chk("estado_pos", 32'(db_estado), 32'(exp_fim));
        pronto = 1'b0;
        medida = bcd_rand();
        tick();
        chk("strobe_unico", 32'(dado_valido), 32'd0);
        chk("dado_retido", 32'(dado), 32'(ultimo));
    endtask

    // Called one cycle after ESPERA was entered.
    task automatic espera_intervalo();
        int n;
        wait_medir(n);
        chk("intervalo", n + 1, INTERVALO);
    endtask

    task automatic falha();
        int w, a, n, tentativas;
`ifdef RETENTATIVA_EN
        tentativas = 2;
`else
        tentativas = 1;
`endif
        for (int k = 0; k < tentativas; k++) begin
            if (k > 0) begin
                wait_medir(n);
                chk("retenta_para_pulso", n, 1);
            end
            w = 0;
            while (medir === 1'b1 && w < 100) begin
                w++;
                tick();
            end
            chk("largura_falha", w, LARGURA);
            a = 0;
            while (db_estado === 4'd2 && a < 5000) begin
                a++;
                tick();
            end
            chk("timeout", a, TIMEOUT);
            if (k < tentativas - 1) begin
                chk("retenta_estado", 32'(db_estado), 32'd6);
                chk("erro_antes_retenta", 32'(erro), 32'd0);
            end
        end
        chk("falha_estado", 32'(db_estado), 32'd4);
        tick();
        chk("erro_setado", 32'(erro), 32'd1);
        chk("dado_inalterado", 32'(dado), 32'(ultimo));
        chk("sem_valido_falha", 32'(dado_valido), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        ligar = 1'b0;
        medir_manual = 1'b0;
        pronto = 1'b0;
        medida = '0;
        ultimo = '0;
        repeat (10) tick();
        chk("rst_medir", 32'(medir), 32'd0);
        chk("rst_dado", 32'(dado), 32'd0);
        chk("rst_valido", 32'(dado_valido), 32'd0);
        chk("rst_erro", 32'(erro), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_estado", 32'(db_estado), 32'd0);
        reset = 1'b0;
        tick();
        chk("inicial_ocioso", 32'(db_estado), 32'd0);

        // first measurement
        ligar = 1'b1;
        tick();
        chk("medir_1ciclo", 32'(medir), 32'd1);
        medicao(300, 12'h100, 1'b0, 1'b0, 4'd5);

        // periodic measurements, fixed then random
        espera_intervalo();
        medicao($urandom_range(TIMEOUT - 1), 12'h075, 1'b0, 1'b0, 4'd5);
        espera_intervalo();
        medicao($urandom_range(TIMEOUT - 1), 12'h170, 1'b0, 1'b0, 4'd5);
        for (int r = 0; r < 4; r++) begin
            espera_intervalo();
            medicao($urandom_range(TIMEOUT - 1), bcd_rand(), 1'b0, 1'b0, 4'd5);
        end

        // sensor never answers
        espera_intervalo();
        falha();

        // manual request pre-empts the interval; another during AGUARDA is ignored
        repeat (99) tick();
        chk("erro_sticky", 32'(erro), 32'd1);
        chk("manual_antes", 32'(medir), 32'd0);
        medir_manual = 1'b1;
        tick();
        medir_manual = 1'b0;
        chk("manual_imediato", 32'(medir), 32'd1);
        medicao($urandom_range(900, 10), bcd_rand(), 1'b0, 1'b1, 4'd5);
        espera_intervalo();

        // ligar drops mid-AGUARDA: measurement completes, then idle
        medicao($urandom_range(900, 10), bcd_rand(), 1'b1, 1'b0, 4'd0);
        n = 0;
        repeat (3000) begin
            tick();
            if (medir === 1'b1) n++;
        end
        chk("sem_medir_desligado", n, 0);
        chk("ocioso_estado", 32'(db_estado), 32'd0);
        chk("ocioso_ocupado", 32'(ocupado), 32'd0);

        // manual request from INICIAL with ligar low
        medir_manual = 1'b1;
        tick();
        medir_manual = 1'b0;
        chk("manual_inicial", 32'(medir), 32'd1);
        medicao($urandom_range(TIMEOUT - 1), bcd_rand(), 1'b0, 1'b0, 4'd0);

        // reset mid-PULSO
        ligar = 1'b1;
        tick();
        chk("pulso_antes_reset", 32'(medir), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("reset_medir", 32'(medir), 32'd0);
        chk("reset_estado", 32'(db_estado), 32'd0);
        chk("reset_erro", 32'(erro), 32'd0);
        chk("reset_dado", 32'(dado), 32'd0);
        chk("reset_valido", 32'(dado_valido), 32'd0);
        ultimo = '0;
        reset = 1'b0;
        tick();
        chk("pos_reset_medir", 32'(medir), 32'd1);

        // pronto rises exactly on the expiry cycle: pronto wins
        medicao(TIMEOUT - 1, bcd_rand(), 1'b0, 1'b0, 4'd5);
        ligar = 1'b0;
        repeat (3) tick();
        chk("fim_estado", 32'(db_estado), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
